fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the decode-stage control logic and drives the opcode and mode fields that the main control decoder consumes. It owns the PC and the instruction-memory request handshake. It obeys stall, kill and pc_src from the PC control and hazard logic.

Parameters:
PC_W, 16, PC and instruction-address width (word addressed)
INSTR_W, 16, instruction width
RESET_PC, 0, PC value after reset
NOP_INSTR, 16'hF000, instruction word loaded into IF/ID on a bubble or kill

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and IF/ID (from hazard detect)
kill  in  1  flush IF/ID to a bubble
pc_src  in  1  redirect PC to branch_target
branch_target  in  PC_W  redirect address
imem_req  out  1  instruction read request
imem_addr  out  PC_W  request address; stable while imem_req=1
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_W  instruction word
if_id_instr  out  INSTR_W  registered instruction
if_id_pc1  out  PC_W  registered PC+1 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
opCode  out  4  if_id_instr[15:12]
mode  out  1  if_id_instr[0]
perf_fetch_cnt  out  32  accepted-instruction count (optional feature)
perf_bubble_cnt  out  32  bubble cycles count (optional feature)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, req_addr=RESET_PC, state=S_FETCH, imem_req=0, if_id_instr=NOP_INSTR, if_id_pc1=0, if_id_valid=0, skid buffer empty, counters=0. imem_req rises the first cycle after release.
- States:
  - S_FETCH: imem_req=1, imem_addr=req_addr.
  - S_DROP: imem_req=1; the outstanding response is discarded.
  - S_HELD: imem_req=0; the skid buffer holds a fetched word.
- imem handshake: a request is never withdrawn or changed before imem_ack. Any number of wait cycles is legal. Ack in the same cycle as the request start gives zero wait states.
- Event priority per cycle: reset > pc_src > kill > stall > normal.
- S_FETCH, ack, pc_src=0, stall=0:
  - IF/ID <= {rdata, req_addr+1, valid=1}.
  - pc = req_addr = req_addr+1.
  - Stay in S_FETCH. Throughput is 1 instruction per cycle with zero-wait memory.
- S_FETCH, ack, stall=1, pc_src=0: word and PC+1 go to the skid buffer. pc advances; IF/ID holds. Go to S_HELD.
- S_HELD, stall=0:
  - IF/ID loads from the buffer (or takes a bubble if kill=1).
  - req_addr=pc. Go to S_FETCH.
- S_HELD, stall=1: hold everything.
- pc_src=1 in any state: pc=branch_target. The next state depends on the request:
  - If ack is present this cycle, or the state is S_HELD: the response or buffer is discarded, req_addr=branch_target, go to S_FETCH.
  - If a request is outstanding without ack: go to S_DROP. S_DROP keeps the old req_addr until ack, discards the data, then sets req_addr=pc and returns to S_FETCH.
- A further pc_src in S_DROP updates pc only.
- kill=1 (pc_src or not): IF/ID <= {NOP_INSTR, 0, valid=0} regardless of stall.
- Not stalled and no instruction accepted this cycle (wait state, S_DROP): IF/ID takes a bubble (NOP_INSTR, valid=0).
- PC wraps modulo 2^PC_W; 16'hFFFF+1 = 0 with no flag.
- opCode and mode are combinational slices of if_id_instr; no added latency. Decode sees an instruction one cycle after its ack.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: perf_fetch_cnt increments on every IF/ID load with valid=1. perf_bubble_cnt increments on every cycle where IF/ID is not stalled and loads valid=0. Both are 32-bit, wrap, and reset to 0.
- Undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Reset release, zero-wait memory returning addr-indexed words → imem_addr 0,1,2,3 on consecutive cycles; if_id_valid=1 from cycle 2; opCode tracks word[15:12].
- imem_ack delayed 3 cycles at addr 5 → imem_addr held at 5 for 4 cycles; 3 bubbles with if_id_valid=0, if_id_instr=16'hF000; then the word for addr 5 with if_id_pc1=6.
- Ack at addr 8 while stall=1 for 2 cycles → IF/ID unchanged for 2 cycles, imem_req=0; the addr-8 word enters IF/ID the cycle after stall falls; the next request is addr 9.
- pc_src=1, kill=1, branch_target=0x40, while addr 0x12 is outstanding (ack 2 cycles later) → imem_addr stays 0x12 until ack; data is dropped; next request is 0x40; if_id_valid=0 throughout.
- pc=16'hFFFF fetched → if_id_pc1=0, next imem_addr=0.
- rst_n low mid-S_DROP → outputs return to reset values immediately; the first request after release is RESET_PC. With FETCH_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake with skid buffer, IF/ID register.
// Optional perf counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'hF000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               kill,
  input  logic               pc_src,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic [3:0]         opCode,
  output logic               mode,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
);

  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HELD} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     req_addr_q, req_addr_d;
  logic                imem_req_q, imem_req_d;
  logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]     skid_pc1_q, skid_pc1_d;
  logic [INSTR_W-1:0]  if_instr_q, if_instr_d;
  logic [PC_W-1:0]     if_pc1_q, if_pc1_d;
  logic                if_vld_q, if_vld_d;

  logic                ack;
  logic                accept;
  logic                if_load;
  logic [INSTR_W-1:0]  acc_instr;
  logic [PC_W-1:0]     acc_pc1;
  logic [PC_W-1:0]     fetch_pc1;

  always_comb begin
    // An ack is only meaningful against a live request.
    ack          = imem_ack & imem_req_q;
    fetch_pc1    = req_addr_q + PC_W'(1);
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc1_d   = skid_pc1_q;
    accept       = 1'b0;
    acc_instr    = imem_rdata;
    acc_pc1      = fetch_pc1;

    case (state_q)
      S_FETCH: begin
        if (pc_src) begin
          pc_d = branch_target;
          if (ack || !imem_req_q) req_addr_d = branch_target;
          else                    state_d    = S_DROP;
        end else if (ack) begin
          pc_d       = fetch_pc1;
          req_addr_d = fetch_pc1;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc1_d   = fetch_pc1;
            state_d      = S_HELD;
          end else begin
            accept = 1'b1;
          end
        end
      end
      S_HELD: begin
        if (pc_src) begin
          pc_d       = branch_target;
          req_addr_d = branch_target;
          state_d    = S_FETCH;
        end else if (!stall) begin
          accept     = 1'b1;
          acc_instr  = skid_instr_q;
          acc_pc1    = skid_pc1_q;
          req_addr_d = pc_q;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        if (pc_src) pc_d = branch_target;
        if (ack) begin
          req_addr_d = pc_d;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    imem_req_d = (state_d != S_HELD);

    // kill beats stall; an unstalled cycle with nothing accepted is a bubble.
    if_load    = kill | accept | ~stall;
    if_instr_d = if_instr_q;
    if_pc1_d   = if_pc1_q;
    if_vld_d   = if_vld_q;
    if (kill || (if_load && !accept)) begin
      if_instr_d = NOP_INSTR;
      if_pc1_d   = '0;
      if_vld_d   = 1'b0;
    end else if (accept) begin
      if_instr_d = acc_instr;
      if_pc1_d   = acc_pc1;
      if_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      imem_req_q   <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc1_q   <= '0;
      if_instr_q   <= NOP_INSTR;
      if_pc1_q     <= '0;
      if_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      imem_req_q   <= imem_req_d;
      skid_instr_q <= skid_instr_d;
      skid_pc1_q   <= skid_pc1_d;
      if_instr_q   <= if_instr_d;
      if_pc1_q     <= if_pc1_d;
      if_vld_q     <= if_vld_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = req_addr_q;
  assign if_id_instr = if_instr_q;
  assign if_id_pc1   = if_pc1_q;
  assign if_id_valid = if_vld_q;
  assign opCode      = if_instr_q[15:12];
  assign mode        = if_instr_q[0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (if_load && if_vld_d)                fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (if_load && !if_vld_d && !stall)     bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_fetch_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait stream, wait states, stall skid,
// redirect while outstanding, PC wrap and reset in the middle of a drop.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, kill, pc_src;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic [3:0]  opCode;
  logic        mode;
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;

  logic auto_ack, man_ack;
  int   tests = 0;
  int   fails = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill), .pc_src(pc_src),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid), .opCode(opCode), .mode(mode),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  // Memory image: word at address a is {a[3:0], ~a[11:0]}.
  function automatic logic [15:0] word(input logic [15:0] a);
    return {a[3:0], ~a[11:0]};
  endfunction

  assign imem_rdata = word(imem_addr);
  assign imem_ack   = auto_ack ? imem_req : man_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr,
                          input logic [15:0] pc1, input logic vld);
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
    chk({tag, ".pc1"},   32'(if_id_pc1),   32'(pc1));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(vld));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; kill = 1'b0; pc_src = 1'b0;
    branch_target = 16'h0; auto_ack = 1'b1; man_ack = 1'b0;
    #12;
    chk("rst.req",  32'(imem_req),  32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk_ifid("rst", 16'hF000, 16'h0, 1'b0);
    chk("rst.opCode", 32'(opCode), 32'hF);
    chk("rst.mode",   32'(mode),   32'd0);
    chk("rst.fcnt",   perf_fetch_cnt,  32'd0);
    chk("rst.bcnt",   perf_bubble_cnt, 32'd0);

    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rel.req",  32'(imem_req),  32'd1);
    chk("rel.addr", 32'(imem_addr), 32'd0);
    step();
    chk("zw.addr1", 32'(imem_addr), 32'd1);
    chk_ifid("zw0", word(16'd0), 16'd1, 1'b1);
    chk("zw0.opCode", 32'(opCode), 32'd0);
    step();
    chk("zw.addr2", 32'(imem_addr), 32'd2);
    chk("zw1.opCode", 32'(opCode), 32'd1);
    chk("zw1.mode",   32'(mode),   32'(word(16'd1) & 16'h1));
    step();
    chk("zw.addr3", 32'(imem_addr), 32'd3);
    chk("zw2.opCode", 32'(opCode), 32'd2);

    // wait states at address 5
    step(); step();
    chk("ws.addr5", 32'(imem_addr), 32'd5);
    auto_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws.hold_addr", 32'(imem_addr), 32'd5);
      chk("ws.hold_req",  32'(imem_req),  32'd1);
      chk_ifid("ws.bubble", 16'hF000, 16'h0, 1'b0);
    end
    man_ack = 1'b1;
    step();
    chk_ifid("ws.word5", word(16'd5), 16'd6, 1'b1);
    chk("ws.addr6", 32'(imem_addr), 32'd6);
    man_ack = 1'b0; auto_ack = 1'b1;

    // ack at address 8 while stalled
    step(); step();
    chk("st.addr8", 32'(imem_addr), 32'd8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("st.req", 32'(imem_req), 32'd0);
      chk_ifid("st.hold", word(16'd7), 16'd8, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_ifid("st.word8", word(16'd8), 16'd9, 1'b1);
    chk("st.req9",  32'(imem_req),  32'd1);
    chk("st.addr9", 32'(imem_addr), 32'd9);
    step();
    chk_ifid("st.word9", word(16'd9), 16'd10, 1'b1);

`ifndef FETCH_PERF_CNT_EN
    chk("tie.fcnt", perf_fetch_cnt,  32'd0);
    chk("tie.bcnt", perf_bubble_cnt, 32'd0);
`endif

    // redirect with kill while 0x12 is outstanding
    for (int i = 0; i < 8; i++) step();
    chk("br.addr12", 32'(imem_addr), 32'h12);
    auto_ack = 1'b0; man_ack = 1'b0;
    pc_src = 1'b1; kill = 1'b1; branch_target = 16'h0040;
    step();
    pc_src = 1'b0; kill = 1'b0;
    chk("br.keep1", 32'(imem_addr), 32'h12);
    chk("br.req1",  32'(imem_req),  32'd1);
    chk("br.vld1",  32'(if_id_valid), 32'd0);
    step();
    chk("br.keep2", 32'(imem_addr), 32'h12);
    chk("br.vld2",  32'(if_id_valid), 32'd0);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    chk("br.addr40", 32'(imem_addr), 32'h40);
    chk_ifid("br.drop", 16'hF000, 16'h0, 1'b0);
    auto_ack = 1'b1;
    step();
    chk_ifid("br.word40", word(16'h40), 16'h41, 1'b1);

    // PC wrap
    pc_src = 1'b1; branch_target = 16'hFFFF;
    step();
    pc_src = 1'b0;
    chk("wr.addrFFFF", 32'(imem_addr), 32'hFFFF);
    chk("wr.vld0",     32'(if_id_valid), 32'd0);
    step();
    chk_ifid("wr.wordFFFF", word(16'hFFFF), 16'h0, 1'b1);
    chk("wr.addr0", 32'(imem_addr), 32'd0);
    step();
    chk("wr.addr1", 32'(imem_addr), 32'd1);

    // reset in the middle of S_DROP
    auto_ack = 1'b0;
    pc_src = 1'b1; branch_target = 16'h0080;
    step();
    pc_src = 1'b0;
    chk("rd.keep", 32'(imem_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd.req",  32'(imem_req),  32'd0);
    chk("rd.addr", 32'(imem_addr), 32'd0);
    chk_ifid("rd", 16'hF000, 16'h0, 1'b0);
    chk("rd.fcnt", perf_fetch_cnt,  32'd0);
    chk("rd.bcnt", perf_bubble_cnt, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    auto_ack = 1'b1;
    step();
    chk("rd.rel_req",  32'(imem_req),  32'd1);
    chk("rd.rel_addr", 32'(imem_addr), 32'd0);
    step();
    chk_ifid("rd.word0", word(16'd0), 16'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
